// File: rtl/interrupt_controller.sv
// rtl/interrupt_controller.sv - prioritised interrupt request feeder with ack/EOI handshake
module interrupt_controller #(
   parameter int                 N_IRQ    = 4,
   parameter int                 ID_W     = 2,
   parameter logic [N_IRQ-1:0]   MASK_RST = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N_IRQ-1:0]  irq_in,
   input  logic              mask_we,
   input  logic [N_IRQ-1:0]  mask_wdata,
   input  logic              int_ack,
   input  logic              eoi,
   output logic              interrupt,
   output logic [ID_W-1:0]   irq_id,
   output logic              in_service,
   output logic [N_IRQ-1:0]  pending
);

   typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

   state_t           state_q, state_d;
   logic [ID_W-1:0]  id_d;
   logic [N_IRQ-1:0] sync1, s, s_d;
   logic [N_IRQ-1:0] mask;
   logic [N_IRQ-1:0] rise, eligible, clr;
   logic [ID_W-1:0]  sel;

   assign rise     = s & ~s_d;
   assign eligible = pending & ~mask;

   // Fixed priority: scanning downward leaves the lowest eligible index in sel.
   always_comb begin
      sel = '0;
      for (int i = N_IRQ - 1; i >= 0; i--) begin
         if (eligible[i]) sel = ID_W'(i);
      end
   end

   always_comb begin
      clr = '0;
      for (int i = 0; i < N_IRQ; i++) begin
         clr[i] = (state_q == REQ) && int_ack && (irq_id == ID_W'(i));
      end
   end

   always_comb begin
      state_d = state_q;
      id_d    = irq_id;
      case (state_q)
         IDLE: begin
            if (eligible != '0) begin
               state_d = REQ;
               id_d    = sel;
            end
         end
         REQ: begin
            if (int_ack) state_d = SERVICE;
         end
         SERVICE: begin
            if (eoi) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1      <= '0;
         s          <= '0;
         s_d        <= '0;
         pending    <= '0;
         mask       <= MASK_RST;
         state_q    <= IDLE;
         irq_id     <= '0;
         interrupt  <= 1'b0;
         in_service <= 1'b0;
      end else begin
         sync1      <= irq_in;
         s          <= sync1;
         s_d        <= s;
         // A fresh edge on the bit being acknowledged must survive the clear.
         pending    <= (pending & ~clr) | rise;
         if (mask_we) mask <= mask_wdata;
         state_q    <= state_d;
         irq_id     <= id_d;
         interrupt  <= (state_d == REQ);
         in_service <= (state_d == SERVICE);
      end
   end

endmodule

// File: tb/tb_interrupt_controller.sv
// tb/tb_interrupt_controller.sv - scoreboard bench for interrupt_controller
module tb_interrupt_controller;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [3:0] irq_in = '0;
   logic       mask_we = 1'b0;
   logic [3:0] mask_wdata = '0;
   logic       int_ack = 1'b0;
   logic       eoi = 1'b0;
   logic       interrupt;
   logic [1:0] irq_id;
   logic       in_service;
   logic [3:0] pending;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic       intr;
      logic [1:0] id;
      logic       ins;
      logic [3:0] pend;
   } exp_t;

   exp_t sb[$];

   // Reference model: request levels seen at each clock, pending set, mask, handshake phase.
   logic [3:0] h1, h2, h3;
   logic [3:0] m_pend, m_mask;
   int         m_phase;   // 0 idle, 1 requesting, 2 servicing
   int         m_id;

   interrupt_controller #(.N_IRQ(4), .ID_W(2), .MASK_RST(4'b0000)) dut (
      .clk(clk), .rst(rst), .irq_in(irq_in), .mask_we(mask_we), .mask_wdata(mask_wdata),
      .int_ack(int_ack), .eoi(eoi), .interrupt(interrupt), .irq_id(irq_id),
      .in_service(in_service), .pending(pending)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      h1 = '0; h2 = '0; h3 = '0;
      m_pend = '0; m_mask = 4'b0000; m_phase = 0; m_id = 0;
   endtask

   task automatic model_step();
      logic [3:0] rise, elig, nxt;
      exp_t e;
      // An input level first seen at clock k marks pending at clock k+2.
      rise = h2 & ~h3;
      h3 = h2; h2 = h1; h1 = irq_in;
      elig = m_pend & ~m_mask;
      nxt = m_pend;
      if (m_phase == 0) begin
         if (elig != 0) begin
            m_phase = 1;
            for (int i = 3; i >= 0; i--) if (elig[i]) m_id = i;
         end
      end else if (m_phase == 1) begin
         if (int_ack) begin
            nxt[m_id] = 1'b0;
            m_phase = 2;
         end
      end else begin
         if (eoi) m_phase = 0;
      end
      m_pend = nxt | rise;
      if (mask_we) m_mask = mask_wdata;
      e.intr = (m_phase == 1);
      e.ins  = (m_phase == 2);
      e.id   = 2'(m_id);
      e.pend = m_pend;
      sb.push_back(e);
   endtask

   task automatic cycle();
      @(posedge clk);
      if (rst) model_step();
      #1;
      int_ack = 1'b0;
      eoi     = 1'b0;
      mask_we = 1'b0;
   endtask

   task automatic wait_req();
      for (int n = 0; n < 40 && m_phase != 1; n++) cycle();
      if (m_phase != 1) begin
         checks++;
         errors++;
         $display("FAIL wait_req: model never reached request phase (phase %0d, want 1)", m_phase);
      end
   endtask

   task automatic serve();
      wait_req();
      int_ack = 1'b1;
      cycle();
      repeat (3) cycle();
      eoi = 1'b1;
      cycle();
      cycle();
   endtask

   task automatic pulse(input logic [3:0] lines);
      irq_in = lines;
      repeat (3) cycle();
      irq_in = '0;
   endtask

   always @(negedge clk) begin
      if (rst && sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         checks++;
         if (interrupt !== e.intr || irq_id !== e.id || in_service !== e.ins || pending !== e.pend) begin
            errors++;
            $display("FAIL outputs t=%0t: got int=%b id=%0d ins=%b pend=%b, want int=%b id=%0d ins=%b pend=%b",
                     $time, interrupt, irq_id, in_service, pending, e.intr, e.id, e.ins, e.pend);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;

      // Quiet lines after reset
      repeat (6) cycle();

      // Single request, full handshake
      pulse(4'b0100);
      serve();

      // Two simultaneous requests served in priority order
      pulse(4'b1010);
      serve();
      serve();

      // Masked request released by a mask write
      mask_wdata = 4'b0001; mask_we = 1'b1;
      cycle();
      pulse(4'b0001);
      repeat (8) cycle();
      mask_wdata = 4'b0000; mask_we = 1'b1;
      cycle();
      serve();

      // Re-edge on the line being acknowledged lands on the ack clock
      pulse(4'b0100);
      repeat (4) cycle();
      wait_req();
      irq_in = 4'b0100;
      cycle();
      cycle();
      int_ack = 1'b1;
      cycle();
      irq_in = '0;
      repeat (3) cycle();
      eoi = 1'b1;
      cycle();
      serve();

      // Stray strobes, simultaneous strobes and mask churn under random traffic
      for (int n = 0; n < 600; n++) begin
         irq_in  = irq_in ^ (4'($urandom) & 4'($urandom));
         int_ack = ($urandom_range(0, 2) == 0);
         eoi     = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 15) == 0) begin
            mask_we    = 1'b1;
            mask_wdata = 4'($urandom) & 4'($urandom);
         end
         cycle();
      end

      // Asynchronous reset while a request is outstanding
      irq_in = '0;
      mask_wdata = 4'b0000; mask_we = 1'b1;
      int_ack = 1'b1; eoi = 1'b1;
      cycle();
      repeat (3) begin
         int_ack = 1'b1; eoi = 1'b1;
         cycle();
      end
      repeat (6) cycle();
      pulse(4'b0001);
      wait_req();
      cycle();
      #2;
      sb.delete();
      rst = 1'b0;
      #1;
      checks++;
      if (interrupt !== 1'b0 || in_service !== 1'b0 || pending !== 4'b0000 || irq_id !== 2'd0) begin
         errors++;
         $display("FAIL async_reset: got int=%b ins=%b pend=%b id=%0d, want all 0",
                  interrupt, in_service, pending, irq_id);
      end
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      model_reset();

      // Stray strobes while idle, then a request proving the mask reset value
      int_ack = 1'b1;
      cycle();
      eoi = 1'b1;
      cycle();
      repeat (3) cycle();
      pulse(4'b1000);
      serve();
      repeat (3) cycle();

      @(negedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
